// File: rtl/r_pkg.sv
// r_pkg: shared definitions for the R-channel response arbiter.
//   - ID_WIDTH/DATA_WIDTH/RESP_WIDTH : default R beat field widths
//   - r_beat_t                        : one R beat {id, data, resp, last}
//   - ST_IDLE/ST_LOCKED               : arbiter FSM encodings
//   - rr_pick()                       : round-robin search from a start pointer
package r_pkg;

  localparam int unsigned ID_WIDTH   = 4;
  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned RESP_WIDTH = 2;

  // Upper bound on requesters supported by rr_pick.
  localparam int unsigned MAX_SRC = 8;
  localparam int unsigned PTR_W   = 3;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [RESP_WIDTH-1:0] resp;
    logic                  last;
  } r_beat_t;

  typedef struct packed {
    logic             found;
    logic [PTR_W-1:0] idx;
  } rr_pick_t;

  // First asserted req bit searching ptr, ptr+1, ... wrapping at num_src.
  // ptr must be below num_src; req bits at or above num_src are ignored.
  function automatic rr_pick_t rr_pick(input logic [MAX_SRC-1:0] req,
                                       input logic [PTR_W-1:0]   ptr,
                                       input int unsigned        num_src);
    rr_pick_t    res;
    int unsigned cand;
    res = '0;
    for (int unsigned i = 0; i < MAX_SRC; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= num_src) begin
        cand = cand - num_src;
      end
      if ((i < num_src) && !res.found && req[cand[PTR_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[PTR_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/r_resp_arbiter_core.sv
// rr_arbiter_core: round-robin search plus the rotating priority pointer.
//   clk, rst      : clock, asynchronous active-high reset
//   req           : per-source request
//   advance       : move the pointer past adv_idx this cycle
//   adv_idx       : index of the source that just finished
//   pick_found    : some request is asserted
//   pick_idx      : winning index (valid when pick_found)
//   rr_ptr        : current highest-priority index
module rr_arbiter_core #(
  parameter int unsigned NUM_SRC = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] req,
  input  logic               advance,
  input  logic [IDX_W-1:0]   adv_idx,
  output logic               pick_found,
  output logic [IDX_W-1:0]   pick_idx,
  output logic [IDX_W-1:0]   rr_ptr
);
  import r_pkg::*;

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  rr_pick_t         pick;

  always_comb begin
    pick       = rr_pick(MAX_SRC'(req), PTR_W'(rr_ptr_q), NUM_SRC);
    pick_found = pick.found;
    pick_idx   = IDX_W'(pick.idx);

    rr_ptr_d = rr_ptr_q;
    if (advance) begin
      // Explicit wrap keeps the pointer in range for non-power-of-two counts.
      if (adv_idx == IDX_W'(NUM_SRC - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = adv_idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign rr_ptr = rr_ptr_q;

endmodule

// File: rtl/r_resp_arbiter.sv
// r_resp_arbiter: shares one AXI R channel among NUM_SRC beat sources with
// burst-granular round-robin arbitration and a one-entry output register.
//   clk, rst                        : clock, asynchronous active-high reset
//   src_valid/src_ready             : per-source beat handshake
//   src_id/src_data/src_resp/src_last : packed per-source beat fields
//   m_valid/m_ready, m_id/m_data/m_resp/m_last : R channel to the master
//   busy                            : a burst owns the channel
//   grant_idx                       : current owner (valid while busy)
//   beat_cnt                        : beats accepted in current burst (saturating)
module r_resp_arbiter #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned RESP_WIDTH = 2,
  parameter int unsigned BEAT_CNT_W = 8,
  localparam int unsigned IDX_W     = $clog2(NUM_SRC)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SRC-1:0]           src_valid,
  output logic [NUM_SRC-1:0]           src_ready,
  input  logic [NUM_SRC*ID_WIDTH-1:0]  src_id,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SRC*RESP_WIDTH-1:0] src_resp,
  input  logic [NUM_SRC-1:0]           src_last,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [ID_WIDTH-1:0]          m_id,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic [RESP_WIDTH-1:0]        m_resp,
  output logic                         m_last,
  output logic                         busy,
  output logic [IDX_W-1:0]             grant_idx,
  output logic [BEAT_CNT_W-1:0]        beat_cnt
);
  import r_pkg::*;

  logic [0:0]            state_q, state_d;
  logic [IDX_W-1:0]      grant_idx_q, grant_idx_d;
  logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic                  m_valid_q, m_valid_d;
  logic [ID_WIDTH-1:0]   m_id_q, m_id_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [RESP_WIDTH-1:0] m_resp_q, m_resp_d;
  logic                  m_last_q, m_last_d;

  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;
  logic [IDX_W-1:0]      rr_ptr;
  logic                  rr_advance;

  logic                  locked;
  logic                  slot_free;
  logic                  accept;

  rr_arbiter_core #(
    .NUM_SRC (NUM_SRC)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .req        (src_valid),
    .advance    (rr_advance),
    .adv_idx    (grant_idx_q),
    .pick_found (pick_found),
    .pick_idx   (pick_idx),
    .rr_ptr     (rr_ptr)
  );

  always_comb begin
    locked = (state_q == ST_LOCKED);
    // The output register can take a beat when empty or being drained now.
    slot_free = ~m_valid_q | m_ready;
    accept    = locked & src_valid[grant_idx_q] & slot_free;

    src_ready = '0;
    if (locked && slot_free) begin
      src_ready[grant_idx_q] = 1'b1;
    end

    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    beat_cnt_d  = beat_cnt_q;
    m_id_d      = m_id_q;
    m_data_d    = m_data_q;
    m_resp_d    = m_resp_q;
    m_last_d    = m_last_q;
    rr_advance  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d     = ST_LOCKED;
          grant_idx_d = pick_idx;
          beat_cnt_d  = '0;
        end
      end
      default: begin
        if (accept) begin
          m_id_d   = src_id[grant_idx_q*ID_WIDTH +: ID_WIDTH];
          m_data_d = src_data[grant_idx_q*DATA_WIDTH +: DATA_WIDTH];
          m_resp_d = src_resp[grant_idx_q*RESP_WIDTH +: RESP_WIDTH];
          m_last_d = src_last[grant_idx_q];
          if (beat_cnt_q != '1) begin
            beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
          end
          if (src_last[grant_idx_q]) begin
            state_d    = ST_IDLE;
            rr_advance = 1'b1;
          end
        end
      end
    endcase

    // A same-cycle pop and accept keeps the register full with the new beat.
    m_valid_d = m_valid_q;
    if (accept) begin
      m_valid_d = 1'b1;
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_idx_q <= '0;
      beat_cnt_q  <= '0;
      m_valid_q   <= 1'b0;
      m_id_q      <= '0;
      m_data_q    <= '0;
      m_resp_q    <= '0;
      m_last_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      beat_cnt_q  <= beat_cnt_d;
      m_valid_q   <= m_valid_d;
      m_id_q      <= m_id_d;
      m_data_q    <= m_data_d;
      m_resp_q    <= m_resp_d;
      m_last_q    <= m_last_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_id      = m_id_q;
  assign m_data    = m_data_q;
  assign m_resp    = m_resp_q;
  assign m_last    = m_last_q;
  assign busy      = locked;
  assign grant_idx = grant_idx_q;
  assign beat_cnt  = beat_cnt_q;

  // rr_ptr is internal state of the core; exposed here only for visibility.
  logic rr_ptr_unused;
  assign rr_ptr_unused = ^rr_ptr;

endmodule
